// File: rtl/rr_arb_mux.sv
// rr_arb_mux : N:1 valid/ready mux with round-robin / fixed / manual arbitration and one output register.
// Revision 1.0 - initial release, successor to the combinational 8:1 mux.
`default_nettype none

module rr_arb_mux #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_CH-1:0]        in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  output logic [NUM_CH-1:0]        in_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [SEL_W-1:0]         out_sel_o,
  input  logic                     out_ready_i
);

  localparam logic [1:0] MODE_FIX = 2'b01;
  localparam logic [1:0] MODE_MAN = 2'b10;
  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    rr_ptr_next;
  logic                advance;
  logic                load;
  logic                is_rr;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   grant_data;
  logic [2*NUM_CH-1:0] valid_dbl;
  logic [NUM_CH-1:0]   valid_rot;
  logic                rr_found;
  logic [SEL_W:0]      rr_ofs;
  logic [SEL_W:0]      rr_sum;

  assign advance = ~out_valid_o | out_ready_i;
  assign is_rr   = (mode_i != MODE_FIX) && (mode_i != MODE_MAN);

  // Rotate valids so bit 0 is the pointer channel; the lowest set bit is then the RR winner.
  always_comb begin
    valid_dbl = {in_valid_i, in_valid_i} >> rr_ptr;
    valid_rot = valid_dbl[NUM_CH-1:0];
    rr_found  = 1'b0;
    rr_ofs    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        rr_found = 1'b1;
        rr_ofs   = (SEL_W+1)'(k);
      end
    end
    rr_sum = {1'b0, rr_ptr} + rr_ofs;
    if (rr_sum >= NUM_CH_EXT) begin
      rr_sum = rr_sum - NUM_CH_EXT;
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    case (mode_i)
      MODE_FIX: begin
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          if (in_valid_i[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end
      MODE_MAN: begin
        // An out-of-range sel_i matches no channel, so nothing is ever readied.
        for (int k = 0; k < NUM_CH; k++) begin
          if ((sel_i == SEL_W'(k)) && in_valid_i[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end
      default: begin
        grant_vld = rr_found;
        grant_idx = rr_sum[SEL_W-1:0];
      end
    endcase
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data = in_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign load = grant_vld & advance & ~rst_i;

  always_comb begin
    in_ready_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready_o[k] = load && (grant_idx == SEL_W'(k));
    end
  end

  assign rr_ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_sel_o   <= '0;
      rr_ptr      <= '0;
    end else if (advance) begin
      if (grant_vld) begin
        out_valid_o <= 1'b1;
        out_data_o  <= grant_data;
        out_sel_o   <= grant_idx;
        if (is_rr) begin
          rr_ptr <= rr_ptr_next;
        end
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux : directed stimulus with a queue scoreboard for rr_arb_mux (NUM_CH=8, DATA_W=8).
`default_nettype none

module tb_rr_arb_mux;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic [1:0]               mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_ready;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  rr_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_sel_o   (out_sel),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [DATA_W-1:0] d);
    exp_t e;
    e.sel  = SEL_W'(s);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; direct checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word is consumed on the edge following a cycle with valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sel=%0d data=%0h expected no word", out_sel, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_word", {21'd0, out_sel, out_data}, {21'd0, e.sel, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NUM_CH; k++) in_data[k*DATA_W +: DATA_W] = 8'hA0 + 8'(k);
    rst       = 1'b1;
    mode      = 2'b00;
    sel       = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_sel",   32'(out_sel),   32'd0);
    chk("rst_ready", 32'(in_ready),  32'd0);

    // Round-robin sweep across all channels and back to 0.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) push(i % 8, 8'hA0 + 8'(i % 8));
    for (int i = 0; i < 9; i++) begin
      tick();
      #1;
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Fixed priority: channel 3 is the lowest valid.
    mode     = 2'b01;
    in_valid = 8'b1010_1000;
    for (int i = 0; i < 3; i++) push(3, 8'hA3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fix_ready", 32'(in_ready), 32'h08);
      tick();
      chk("fix_sel", 32'(out_sel), 32'd3);
    end

    // Manual select of channel 5, then valid removed.
    mode     = 2'b10;
    sel      = 3'd5;
    in_valid = 8'h20;
    push(5, 8'hA5);
    #1;
    chk("man_ready", 32'(in_ready), 32'h20);
    tick();
    #1;
    chk("man_data", 32'(out_data), 32'hA5);
    in_valid = 8'h00;
    #1;
    chk("man_ready_idle", 32'(in_ready), 32'h00);
    tick();
    #1;
    chk("man_valid_drop", 32'(out_valid), 32'd0);
    chk("man_sel_hold",   32'(out_sel),   32'd5);

    // Backpressure: pointer is 1, load ch1 then stall three cycles.
    mode     = 2'b00;
    in_valid = 8'hFF;
    push(1, 8'hA1);
    push(2, 8'hA2);
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_ready_stall", 32'(in_ready), 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("bp_sel_hold",  32'(out_sel),  32'd1);
      chk("bp_data_hold", 32'(out_data), 32'hA1);
      chk("bp_ready",     32'(in_ready), 32'h00);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h04);
    tick();
    // Advance the pointer to 6 with grants 3, 4, 5.
    for (int i = 3; i < 6; i++) push(i, 8'hA0 + 8'(i));
    tick();
    tick();
    tick();

    // Wrap and skip from pointer 6 with only channels 0 and 2 valid.
    in_valid = 8'b0000_0101;
    #1;
    chk("wrap_ready", 32'(in_ready), 32'h01);
    push(0, 8'hA0);
    push(2, 8'hA2);
    tick();
    tick();
    tick();
    #1;
    chk("wrap_third_sel", 32'(out_sel),   32'd0);
    chk("wrap_third_vld", 32'(out_valid), 32'd1);

    // Reset while holding a stalled word: the word is discarded.
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst2_ready", 32'(in_ready), 32'h00);
    tick();
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_sel",   32'(out_sel),   32'd0);
    rst       = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    chk("rst2_ptr_ready", 32'(in_ready), 32'h01);
    push(0, 8'hA0);
    tick();
    in_valid = 8'h00;
    tick();
    tick();
    #1;
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N:1 registered multiplexer with valid/ready handshakes on every input channel and on the output. It is the successor to the team's combinational 8:1 mux. It adds three selection modes (round-robin, fixed priority, manual select), backpressure, and one output register stage. It sits wherever several producers share one downstream consumer, such as a datapath merge or a debug/trace funnel.

Parameters:
NUM_CH, 8, number of input channels (>=2).
DATA_W, 8, data width per channel.
SEL_W, $clog2(NUM_CH), width of select/grant index (derived, not overridden).

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
mode_i  input  2  00 round-robin, 01 fixed priority (lowest index wins), 10 manual, 11 treated as 00
sel_i  input  SEL_W  channel index used in manual mode
in_valid_i  input  NUM_CH  per-channel valid
in_data_i  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
in_ready_o  output  NUM_CH  per-channel ready (one-hot or zero)
out_valid_o  output  1  output register holds a word
out_data_o  output  DATA_W  registered data
out_sel_o  output  SEL_W  index of the channel that supplied out_data_o
out_ready_i  input  1  consumer accepts the word

Behaviour:
- Reset: out_valid_o=0, out_data_o=0, out_sel_o=0, round-robin pointer=0. in_ready_o=0 in every cycle rst_i is high. Reset mid-transfer discards the held word with no replay.
- advance = !out_valid_o | out_ready_i. Arbitration happens only when advance=1. If advance=0, in_ready_o=0 and the output register holds its value.
- Grant g is computed combinationally from in_valid_i, mode_i, sel_i and the pointer. in_ready_o = onehot(g) & advance when a grant exists, otherwise 0. in_ready_o must not depend on out_data_o.
- Input transfer on channel k: in_valid_i[k] & in_ready_o[k]. On the same edge: out_data_o <= channel g data, out_sel_o <= g, out_valid_o <= 1.
- If advance=1 and no grant exists: out_valid_o <= 0, and out_data_o/out_sel_o hold their previous values.
- Latency: input accepted at edge n appears on out_*_o after edge n (one cycle). Throughput is 1 word/cycle while out_ready_i=1.
- Round-robin (00): search starts at the pointer and wraps modulo NUM_CH. The first valid channel wins. After a grant to g, pointer <= (g+1) mod NUM_CH, so g=NUM_CH-1 wraps to 0. Pointer is unchanged when there is no grant.
- Fixed priority (01): lowest-index valid channel wins. Pointer is not updated.
- Manual (10): grant=sel_i only if sel_i<NUM_CH and in_valid_i[sel_i]=1, otherwise no grant. Pointer is not updated. If sel_i>=NUM_CH (non-power-of-2 NUM_CH), no channel is ever readied.
- Mode or sel_i changes take effect on the next arbitration cycle. A word already in the output register is never altered.
- Simultaneous out_ready_i=1 and a new grant: the old word is consumed and the new word loaded on the same edge, with no bubble.
- Producers must hold in_valid_i and data stable until accepted. The block does not check this.

Test Plan:
1. Reset, then NUM_CH=8, mode=00, all in_valid_i=8'hFF, channel k data=8'hA0+k, out_ready_i=1 -> out_sel_o sequence 0,1,...,7,0 on consecutive cycles, out_data_o A0..A7,A0, out_valid_o continuously 1 from the first cycle after reset release.
2. mode=01, in_valid_i=8'b1010_1000, out_ready_i=1 -> channel 3 granted every cycle. in_ready_o=8'b0000_1000 and out_sel_o=3 throughout.
3. mode=10, sel_i=5, in_valid_i=8'h20 then 8'h00 -> first cycle out_data_o=ch5 data with out_sel_o=5. With valid removed, out_valid_o falls to 0 on the next cycle and in_ready_o=0.
4. Backpressure: mode=00, all valid, out_ready_i=0 for 3 cycles after the first load -> out_data_o/out_sel_o stable and in_ready_o=0 during the stall. On release the next grant is pointer+1 with no word lost or duplicated (scoreboard compares against the per-channel queues).
5. Wrap and skip: mode=00, pointer at 6, in_valid_i=8'b0000_0101 -> grants 0 then 2 then 0. The pointer wraps past 7 correctly.
6. Assert rst_i for 1 cycle while out_valid_o=1 and out_ready_i=0 -> after that edge out_valid_o=0 and out_sel_o=0. The next round-robin grant with all valid is channel 0.
